// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Moore-style: every datapath select and enable is decoded from the current
// state. The only exceptions are the mem_ready gating in FETCH and the
// illegal_op flag raised in DECODE. Memory states stall until mem_ready.
module multicycle_control #(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     PCSource,
    output logic [2:0]     ALUOp,
    output logic           illegal_op,
    output logic [STW-1:0] state_o
);

    // State codes are visible on state_o, so they are fixed explicitly.
    typedef enum logic [STW-1:0] {
        S_FETCH  = STW'(0),
        S_DECODE = STW'(1),
        S_MEMADR = STW'(2),
        S_MEMRD  = STW'(3),
        S_MEMWB  = STW'(4),
        S_MEMWR  = STW'(5),
        S_EXEC   = STW'(6),
        S_ALUWB  = STW'(7),
        S_BRANCH = STW'(8),
        S_JUMP   = STW'(9),
        S_IMMEX  = STW'(10),
        S_IMMWB  = STW'(11)
    } state_t;

    // Recognised opcodes.
    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001010);

    // ALUOp codes consumed by the ALU control decoder.
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_FUNC = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // ALUSrcB / PCSource select codes.
    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;
    localparam logic [1:0] PCS_ALU   = 2'b00;
    localparam logic [1:0] PCS_OUT   = 2'b01;
    localparam logic [1:0] PCS_JMP   = 2'b10;

    state_t         state;
    state_t         state_n;
    logic [OPW-1:0] op_q;

    // Decoded outputs before the reset override.
    logic           pcwrite_d;
    logic           pcwritecond_d;
    logic           iord_d;
    logic           memread_d;
    logic           memwrite_d;
    logic           irwrite_d;
    logic           memtoreg_d;
    logic           regdst_d;
    logic           regwrite_d;
    logic           alusrca_d;
    logic [1:0]     alusrcb_d;
    logic [1:0]     pcsource_d;
    logic [2:0]     aluop_d;
    logic           illegal_d;

    // State register. op_q captures the opcode in DECODE so later states
    // are immune to the instruction register changing underneath them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            state <= state_n;
            if (state == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Next-state and per-state output decode. Every output defaults to 0.
    always_comb begin
        state_n       = S_FETCH;
        pcwrite_d     = 1'b0;
        pcwritecond_d = 1'b0;
        iord_d        = 1'b0;
        memread_d     = 1'b0;
        memwrite_d    = 1'b0;
        irwrite_d     = 1'b0;
        memtoreg_d    = 1'b0;
        regdst_d      = 1'b0;
        regwrite_d    = 1'b0;
        alusrca_d     = 1'b0;
        alusrcb_d     = SRCB_RT;
        pcsource_d    = PCS_ALU;
        aluop_d       = ALU_ADD;
        illegal_d     = 1'b0;

        case (state)
            S_FETCH: begin
                // PC+4 is written in the same cycle the instruction lands.
                memread_d  = 1'b1;
                alusrcb_d  = SRCB_FOUR;
                irwrite_d  = mem_ready;
                pcwrite_d  = mem_ready;
                state_n    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode decodes.
                alusrcb_d = SRCB_BOFF;
                case (opcode)
                    OP_RTYPE:                         state_n = S_EXEC;
                    OP_LW, OP_SW:                     state_n = S_MEMADR;
                    OP_BEQ:                           state_n = S_BRANCH;
                    OP_J:                             state_n = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_n = S_IMMEX;
                    default: begin
                        illegal_d = 1'b1;
                        state_n   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_d = 1'b1;
                alusrcb_d = SRCB_IMM;
                if (op_q == OP_LW) begin
                    state_n = S_MEMRD;
                end else if (op_q == OP_SW) begin
                    state_n = S_MEMWR;
                end else begin
                    state_n = S_FETCH;
                end
            end
            S_MEMRD: begin
                memread_d = 1'b1;
                iord_d    = 1'b1;
                state_n   = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwrite_d = 1'b1;
                memtoreg_d = 1'b1;
            end
            S_MEMWR: begin
                // Write request held for the whole stall.
                memwrite_d = 1'b1;
                iord_d     = 1'b1;
                state_n    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alusrca_d = 1'b1;
                alusrcb_d = SRCB_RT;
                aluop_d   = ALU_FUNC;
                state_n   = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_d = 1'b1;
                regdst_d   = 1'b1;
            end
            S_BRANCH: begin
                alusrca_d     = 1'b1;
                alusrcb_d     = SRCB_RT;
                aluop_d       = ALU_SUB;
                pcwritecond_d = 1'b1;
                pcsource_d    = PCS_OUT;
            end
            S_JUMP: begin
                pcwrite_d  = 1'b1;
                pcsource_d = PCS_JMP;
            end
            S_IMMEX: begin
                alusrca_d = 1'b1;
                alusrcb_d = SRCB_IMM;
                case (op_q)
                    OP_ANDI: aluop_d = ALU_AND;
                    OP_ORI:  aluop_d = ALU_OR;
                    OP_SLTI: aluop_d = ALU_SLT;
                    default: aluop_d = ALU_ADD;
                endcase
                state_n = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite_d = 1'b1;
            end
            default: begin
                // Unused codes fall back to FETCH with everything off.
                state_n = S_FETCH;
            end
        endcase
    end

    // Reset forces every output low so no enable pulses in the reset cycle,
    // even when the state register holds a stalled memory state.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = 3'b000;
        illegal_op  = 1'b0;
        state_o     = '0;
        if (!reset) begin
            PCWrite     = pcwrite_d;
            PCWriteCond = pcwritecond_d;
            IorD        = iord_d;
            MemRead     = memread_d;
            MemWrite    = memwrite_d;
            IRWrite     = irwrite_d;
            MemtoReg    = memtoreg_d;
            RegDst      = regdst_d;
            RegWrite    = regwrite_d;
            ALUSrcA     = alusrca_d;
            ALUSrcB     = alusrcb_d;
            PCSource    = pcsource_d;
            ALUOp       = aluop_d;
            illegal_op  = illegal_d;
            state_o     = state;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each scenario queues per-cycle
// stimulus with the expected output vector, then plays it and compares.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] state_o;

    multicycle_control #(.OPW(6), .STW(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .illegal_op(illegal_op), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010;
    localparam logic [5:0] BAD = 6'b111111;

    // {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
    //  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal}
    typedef logic [21:0] vec_t;
    typedef struct packed { logic rst; logic [5:0] op; logic mr; } stim_t;

    stim_t st_q[$];
    vec_t  exp_q[$];
    int    vectors;
    int    miscompares;

    function automatic vec_t mk(input logic [3:0] st, input logic pcw, pcwc,
                                iord, mrd, mwr, irw, m2r, rdst, rw, asa,
                                input logic [1:0] asb, pcs,
                                input logic [2:0] aop, input logic ill);
        return {st, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa,
                asb, pcs, aop, ill};
    endfunction

    // Expected output vector per state, written from the control table.
    function automatic vec_t e_zero();         return '0; endfunction
    function automatic vec_t e_fetch(input logic mr);
        return mk(4'd0, mr, 0, 0, 1, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0);
    endfunction
    function automatic vec_t e_decode(input logic ill);
        return mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, ill);
    endfunction
    function automatic vec_t e_memadr();
        return mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b000, 0);
    endfunction
    function automatic vec_t e_memrd();
        return mk(4'd3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic vec_t e_memwb();
        return mk(4'd4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic vec_t e_memwr();
        return mk(4'd5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic vec_t e_exec();
        return mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 0);
    endfunction
    function automatic vec_t e_aluwb();
        return mk(4'd7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic vec_t e_branch();
        return mk(4'd8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b001, 0);
    endfunction
    function automatic vec_t e_jump();
        return mk(4'd9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0);
    endfunction
    function automatic vec_t e_immex(input logic [2:0] aop);
        return mk(4'd10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, aop, 0);
    endfunction
    function automatic vec_t e_immwb();
        return mk(4'd11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
    endfunction

    function automatic vec_t observed();
        return {state_o, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
                illegal_op};
    endfunction

    task automatic push(input logic r, input logic [5:0] op, input logic mr,
                        input vec_t e);
        st_q.push_back({r, op, mr});
        exp_q.push_back(e);
    endtask

    // Drive the next queued stimulus and wait to the sampling point.
    task automatic apply_next(output vec_t e);
        stim_t s;
        s         = st_q.pop_front();
        reset     = s.rst;
        opcode    = s.op;
        mem_ready = s.mr;
        e         = exp_q.pop_front();
        @(negedge clk);
    endtask

    task automatic test_reset();
        vec_t e, g;
        int c = 0;
        push(1, LW, 1, e_zero());
        push(1, SW, 0, e_zero());
        push(0, RT, 0, e_fetch(0));
        while (exp_q.size() > 0) begin
            apply_next(e); g = observed(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL test_reset cyc %0d: got %h expected %h", c, g, e);
            end
            c++; @(posedge clk); #1;
        end
    endtask

    task automatic test_lw();
        vec_t e, g;
        int c = 0;
        push(0, LW, 1, e_fetch(1));
        push(0, LW, 1, e_decode(0));
        push(0, RT, 1, e_memadr());
        push(0, RT, 1, e_memrd());
        push(0, RT, 1, e_memwb());
        // second lw with stalls in FETCH and MEMRD
        push(0, LW, 0, e_fetch(0));
        push(0, LW, 1, e_fetch(1));
        push(0, LW, 1, e_decode(0));
        push(0, SW, 1, e_memadr());
        push(0, SW, 0, e_memrd());
        push(0, SW, 1, e_memrd());
        push(0, SW, 1, e_memwb());
        while (exp_q.size() > 0) begin
            apply_next(e); g = observed(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL test_lw cyc %0d: got %h expected %h", c, g, e);
            end
            c++; @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_stall();
        vec_t e, g;
        int c = 0;
        push(0, SW, 1, e_fetch(1));
        push(0, SW, 1, e_decode(0));
        push(0, LW, 1, e_memadr());
        push(0, LW, 0, e_memwr());
        push(0, LW, 0, e_memwr());
        push(0, LW, 0, e_memwr());
        push(0, LW, 1, e_memwr());
        push(0, RT, 1, e_fetch(1));
        push(0, RT, 1, e_decode(0));
        while (exp_q.size() > 0) begin
            apply_next(e); g = observed(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL test_sw_stall cyc %0d: got %h expected %h", c, g, e);
            end
            c++; @(posedge clk); #1;
        end
    endtask

    // Continues from DECODE of an R-type left by the previous scenario.
    task automatic test_rtype();
        vec_t e, g;
        int c = 0;
        push(0, LW, 1, e_exec());
        push(0, SW, 1, e_aluwb());
        push(0, RT, 1, e_fetch(1));
        push(0, RT, 1, e_decode(0));
        push(0, RT, 0, e_exec());
        push(0, RT, 0, e_aluwb());
        while (exp_q.size() > 0) begin
            apply_next(e); g = observed(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL test_rtype cyc %0d: got %h expected %h", c, g, e);
            end
            c++; @(posedge clk); #1;
        end
    endtask

    // Live opcode is switched away after DECODE; ALUOp must follow op_q.
    task automatic test_imm();
        vec_t e, g;
        int c = 0;
        logic [5:0] ops [4] = '{ORI, ANDI, SLTI, ADDI};
        logic [2:0] aops[4] = '{3'b100, 3'b011, 3'b111, 3'b000};
        for (int i = 0; i < 4; i++) begin
            push(0, ops[i], 1, e_fetch(1));
            push(0, ops[i], 1, e_decode(0));
            push(0, RT, 1, e_immex(aops[i]));
            push(0, BAD, 1, e_immwb());
        end
        while (exp_q.size() > 0) begin
            apply_next(e); g = observed(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL test_imm cyc %0d: got %h expected %h", c, g, e);
            end
            c++; @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        vec_t e, g;
        int c = 0;
        push(0, BEQ, 1, e_fetch(1));
        push(0, BEQ, 1, e_decode(0));
        push(0, RT, 1, e_branch());
        push(0, JMP, 1, e_fetch(1));
        push(0, JMP, 1, e_decode(0));
        push(0, LW, 1, e_jump());
        while (exp_q.size() > 0) begin
            apply_next(e); g = observed(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL test_branch_jump cyc %0d: got %h expected %h", c, g, e);
            end
            c++; @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        vec_t e, g;
        int c = 0;
        push(0, BAD, 1, e_fetch(1));
        push(0, BAD, 1, e_decode(1));
        push(0, BAD, 0, e_fetch(0));
        push(0, 6'b000001, 1, e_fetch(1));
        push(0, 6'b000001, 1, e_decode(1));
        push(0, RT, 0, e_fetch(0));
        while (exp_q.size() > 0) begin
            apply_next(e); g = observed(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL test_illegal cyc %0d: got %h expected %h", c, g, e);
            end
            c++; @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_stall();
        vec_t e, g;
        int c = 0;
        push(0, LW, 1, e_fetch(1));
        push(0, LW, 1, e_decode(0));
        push(0, LW, 1, e_memadr());
        push(0, LW, 0, e_memrd());
        push(0, LW, 0, e_memrd());
        push(1, LW, 0, e_zero());
        push(0, RT, 1, e_fetch(1));
        push(0, RT, 1, e_decode(0));
        push(0, RT, 1, e_exec());
        push(0, RT, 1, e_aluwb());
        push(0, RT, 1, e_fetch(1));
        while (exp_q.size() > 0) begin
            apply_next(e); g = observed(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL test_reset_in_stall cyc %0d: got %h expected %h", c, g, e);
            end
            c++; @(posedge clk); #1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        opcode      = RT;
        mem_ready   = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_lw();
        test_sw_stall();
        test_rtype();
        test_imm();
        test_branch_jump();
        test_illegal();
        test_reset_in_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath mux selects and write enables.
- Produces the 3-bit ALUOp consumed directly by the ALU control decoder. Memory accesses use a mem_ready handshake, so the FSM stalls on slow memory.

Parameters:
- OPW, 6, opcode width.
- STW, 4, state register width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OPW  instruction[31:26] from the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  PC write qualified by ALU Zero (beq).
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR.
- RegDst  out  1  destination register: 0=rt, 1=rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0=PC, 1=rs.
- ALUSrcB  out  2  00=rt, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- ALUOp  out  3  000 add, 001 sub (branch), 010 R-type funct, 011 andi, 100 ori, 111 slti.
- illegal_op  out  1  unrecognised opcode detected in DECODE.
- state_o  out  STW  current state, for debug.

Behaviour:
- Reset: synchronous; reset=1 at a rising edge puts state in FETCH and clears op_q.
- While reset is high, outputs are forced to: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, illegal_op = 0; all selects = 0; ALUOp = 000; state_o = 0.
- Reset overrides any in-flight state, including stalled MEMRD and MEMWR; no write enable may pulse in the reset cycle.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IMMEX=10, IMMWB=11. Codes 12-15 are unreachable and go to FETCH next cycle with all enables 0.
- Outputs are decoded from state; the only exceptions are mem_ready gating and illegal_op. Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target precompute).
  - Latches opcode into op_q.
  - Next state: 000000 -> EXEC; 100011 (lw) or 101011 (sw) -> MEMADR; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; 001000 (addi), 001100 (andi), 001101 (ori), 001010 (slti) -> IMMEX.
  - Any other opcode: illegal_op=1 for this cycle only, then FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Goes to MEMRD if op_q is lw, MEMWR if sw.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Then FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready=1, then FETCH. MemWrite stays high for every stall cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Then ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01. Then FETCH.
- JUMP: PCWrite=1, PCSource=10. Then FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10, ALUOp decoded from op_q (not the live opcode): addi 000, andi 011, ori 100, slti 111. Then IMMWB.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0. Then FETCH.
- Cycle counts with mem_ready tied high:
  - lw = 5.
  - sw = 4.
  - R-type = 4.
  - addi/andi/ori/slti = 4.
  - beq = 3.
  - j = 3.
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- The opcode input may change after DECODE without effect.

Test Plan:
- Reset, then lw (100011) with mem_ready=1 -> states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4; IRWrite=1 only in the first cycle.
- sw (101011), mem_ready low for 3 cycles in MEMWR -> state 5 held 4 cycles with MemWrite=1 throughout. RegWrite never 1. Then FETCH.
- R-type (000000) -> EXEC with ALUOp=010, ALUSrcB=00; ALUWB with RegDst=1, RegWrite=1. Total 4 cycles.
- ori (001101), opcode input changed to 000000 during IMMEX -> ALUOp=100, ALUSrcB=10 in IMMEX. beq -> ALUOp=001, PCWriteCond=1, PCSource=01 in state 8.
- Opcode 111111 -> illegal_op=1 for exactly the DECODE cycle; next state FETCH; no RegWrite, MemWrite or PCWrite pulse.
- Reset asserted during a MEMRD stall (mem_ready=0) -> all enables 0 in the reset cycle; state_o=0 after the edge; the next fetch proceeds normally.
